// File: rtl/config_pkg.sv
// Shared types and helpers for the configuration-chain cells.
package config_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } cfg_state_t;

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/config_beat_counter.sv
// Saturating beat counter and load-tracking FSM for one configuration cell.
module config_beat_counter
    import config_pkg::*;
#(
    parameter int BEATS = 8,
    parameter int CNT_W = $clog2(BEATS + 1)
) (
    input  logic       Config_Clock,
    input  logic       Config_Reset,
    input  logic       shift,
    input  logic       commit,
    input  logic       capture,
    output cfg_state_t state,
    output logic       loaded
);

    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    cfg_state_t       state_nxt;

    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            count <= '0;
            state <= EMPTY;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // State is a pure function of the beat count, so it is derived from the next count.
    always_comb begin
        count_nxt = count;
        if (commit && state == FULL) begin
            count_nxt = shift ? CNT_W'(1) : '0;
        end else if (capture && !commit) begin
            count_nxt = BEATS_C;
        end else if (shift && count != BEATS_C) begin
            count_nxt = count + CNT_W'(1);
        end

        if (count_nxt == '0) begin
            state_nxt = EMPTY;
        end else if (count_nxt == BEATS_C) begin
            state_nxt = FULL;
        end else begin
            state_nxt = FILLING;
        end
    end

    always_comb begin
        loaded = (state == FULL);
    end

endmodule

// File: rtl/config_cell_dbuf.sv
// Double-buffered multi-lane configuration chain cell with bypass stage.
// Optional readback capture port when CONFIG_READBACK_EN is defined.
module config_cell_dbuf
    import config_pkg::*;
#(
    parameter int              SIZE        = 8,
    parameter int              LANES       = 1,
    parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
    input  logic             Config_Clock,
    input  logic             Config_Reset,
    input  logic [LANES-1:0] ConfigIn,
    input  logic             shift_en,
    input  logic             commit,
    input  logic             bypass,
`ifdef CONFIG_READBACK_EN
    input  logic             capture,
`endif
    output logic [LANES-1:0] ConfigOut,
    output logic [SIZE-1:0]  select,
    output logic             loaded,
    output logic             err
);

    localparam int BEATS   = cdiv(SIZE, LANES);
    localparam int SHIFT_W = BEATS * LANES;

    logic [SHIFT_W-1:0] shadow;
    logic [SHIFT_W-1:0] shadow_shift;
    logic [LANES-1:0]   byp_q;
    logic               shift;
    logic               cap;
    cfg_state_t         state;

`ifdef CONFIG_READBACK_EN
    assign cap = capture;
`else
    assign cap = 1'b0;
`endif

    assign shift = shift_en & ~bypass;

    generate
        if (BEATS == 1) begin : g_single
            assign shadow_shift = ConfigIn;
        end else begin : g_multi
            assign shadow_shift = {ConfigIn, shadow[SHIFT_W-1:LANES]};
        end
    endgenerate

    config_beat_counter #(
        .BEATS(BEATS)
    ) u_counter (
        .Config_Clock(Config_Clock),
        .Config_Reset(Config_Reset),
        .shift       (shift),
        .commit      (commit),
        .capture     (cap),
        .state       (state),
        .loaded      (loaded)
    );

    // Capture reloads the shadow with the live config so it shifts out for readback.
    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            shadow <= '0;
            byp_q  <= '0;
        end else begin
            if (cap && !commit) begin
                shadow <= SHIFT_W'(select);
            end else if (shift) begin
                shadow <= shadow_shift;
            end
            if (shift_en && bypass) begin
                byp_q <= ConfigIn;
            end
        end
    end

    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            select <= RESET_VALUE;
            err    <= 1'b0;
        end else if (commit) begin
            if (state == FULL) begin
                select <= shadow[SIZE-1:0];
            end else begin
                err <= 1'b1;
            end
        end
    end

    assign ConfigOut = bypass ? byp_q : shadow[LANES-1:0];

endmodule

// File: tb/tb_config_cell_dbuf.sv
// Directed scoreboard bench for config_cell_dbuf (single cells, 3-lane cell, bypassed chain).
module tb_config_cell_dbuf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Cell d1: SIZE=8, LANES=1
    logic       in1 = 1'b0, sh1 = 1'b0, cm1 = 1'b0, by1 = 1'b0;
    logic       out1, ld1, er1;
    logic [7:0] sel1;
    // Cell d3: SIZE=8, LANES=3
    logic [2:0] in3 = '0, out3;
    logic       sh3 = 1'b0, cm3 = 1'b0, ld3, er3;
    logic [7:0] sel3;
    // Chain ca -> cb
    logic       inc = 1'b0, shc = 1'b0, cma = 1'b0, cmb = 1'b0, bya = 1'b0;
    logic       outa, outb, lda, ldb, era, erb;
    logic [7:0] sela, selb;
`ifdef CONFIG_READBACK_EN
    logic       cap1 = 1'b0, cap3 = 1'b0, capa = 1'b0, capb = 1'b0;
`endif

    config_cell_dbuf #(.SIZE(8), .LANES(1), .RESET_VALUE(8'h5A)) d1 (
        .Config_Clock(clk), .Config_Reset(rst), .ConfigIn(in1), .shift_en(sh1),
        .commit(cm1), .bypass(by1),
`ifdef CONFIG_READBACK_EN
        .capture(cap1),
`endif
        .ConfigOut(out1), .select(sel1), .loaded(ld1), .err(er1));

    config_cell_dbuf #(.SIZE(8), .LANES(3), .RESET_VALUE(8'h00)) d3 (
        .Config_Clock(clk), .Config_Reset(rst), .ConfigIn(in3), .shift_en(sh3),
        .commit(cm3), .bypass(1'b0),
`ifdef CONFIG_READBACK_EN
        .capture(cap3),
`endif
        .ConfigOut(out3), .select(sel3), .loaded(ld3), .err(er3));

    config_cell_dbuf #(.SIZE(8), .LANES(1), .RESET_VALUE(8'h5A)) ca (
        .Config_Clock(clk), .Config_Reset(rst), .ConfigIn(inc), .shift_en(shc),
        .commit(cma), .bypass(bya),
`ifdef CONFIG_READBACK_EN
        .capture(capa),
`endif
        .ConfigOut(outa), .select(sela), .loaded(lda), .err(era));

    config_cell_dbuf #(.SIZE(8), .LANES(1), .RESET_VALUE(8'h5A)) cb (
        .Config_Clock(clk), .Config_Reset(rst), .ConfigIn(outa), .shift_en(shc),
        .commit(cmb), .bypass(1'b0),
`ifdef CONFIG_READBACK_EN
        .capture(capb),
`endif
        .ConfigOut(outb), .select(selb), .loaded(ldb), .err(erb));

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic        mdl[$];

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic beat1(input logic b, input logic c);
        in1 = b; sh1 = 1'b1; cm1 = c;
        tick();
        sh1 = 1'b0; cm1 = 1'b0;
    endtask

    task automatic commit1();
        cm1 = 1'b1;
        tick();
        cm1 = 1'b0;
    endtask

    task automatic beat3(input logic [2:0] v);
        in3 = v; sh3 = 1'b1;
        tick();
        sh3 = 1'b0;
    endtask

    task automatic beatc(input logic b);
        inc = b; shc = 1'b1;
        tick();
        shc = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_sel;
        logic       b;
        logic       cb_bits[$];

        // Reset state
        tick();
        push_exp(32'h5A); chk("rst_select", 32'(sel1));
        push_exp(0);      chk("rst_loaded", 32'(ld1));
        push_exp(0);      chk("rst_err", 32'(er1));
        push_exp(0);      chk("rst_out", 32'(out1));
        rst = 1'b0;

        // Serial load of A5 then commit
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            beat1(pat[i], 1'b0);
            if (i == 6) begin push_exp(0); chk("loaded_at7", 32'(ld1)); end
        end
        push_exp(1); chk("loaded_at8", 32'(ld1));
        push_exp(8); chk("count_at8", 32'(d1.u_counter.count));
        commit1();
        push_exp(32'hA5); chk("commit_select", 32'(sel1));
        push_exp(0);      chk("commit_loaded", 32'(ld1));
        push_exp(0);      chk("commit_err", 32'(er1));
        push_exp(0);      chk("commit_count", 32'(d1.u_counter.count));

        // Continued shifting passes old shadow contents downstream
        for (int i = 0; i < 8; i++) mdl.push_back(pat[i]);
        for (int i = 0; i < 10; i++) begin
            b = 1'($urandom_range(0, 1));
            void'(mdl.pop_front());
            mdl.push_back(b);
            push_exp(32'(mdl[0]));
            beat1(b, 1'b0);
            chk("pass_out", 32'(out1));
        end
        push_exp(8); chk("count_saturates", 32'(d1.u_counter.count));
        for (int i = 0; i < 8; i++) exp_sel[i] = mdl[i];
        commit1();
        push_exp(32'(exp_sel)); chk("commit2_select", 32'(sel1));

        // Commit before a complete load sets sticky err
        do_reset();
        for (int i = 0; i < 3; i++) beat1(1'b1, 1'b0);
        commit1();
        push_exp(32'h5A); chk("early_select", 32'(sel1));
        push_exp(1);      chk("early_err", 32'(er1));
        push_exp(3);      chk("early_count", 32'(d1.u_counter.count));
        for (int i = 0; i < 5; i++) beat1(1'b0, 1'b0);
        commit1();
        push_exp(32'h07); chk("late_select", 32'(sel1));
        push_exp(1);      chk("err_sticky", 32'(er1));
        do_reset();
        push_exp(0);      chk("err_cleared", 32'(er1));

        // Commit with simultaneous shift in FULL
        pat = 8'($urandom());
        for (int i = 0; i < 8; i++) beat1(pat[i], 1'b0);
        beat1(~pat[0], 1'b1);
        push_exp(32'(pat)); chk("cs_select", 32'(sel1));
        push_exp(1);        chk("cs_count", 32'(d1.u_counter.count));
        push_exp(1);        chk("cs_state", 32'(d1.u_counter.state));
        push_exp(0);        chk("cs_loaded", 32'(ld1));

        // Asynchronous reset in the middle of a load
        do_reset();
        for (int i = 0; i < 8; i++) beat1(1'b1, 1'b0);
        commit1();
        for (int i = 0; i < 4; i++) beat1(1'b1, 1'b0);
        push_exp(4);     chk("pre_rst_count", 32'(d1.u_counter.count));
        push_exp(1);     chk("pre_rst_out", 32'(out1));
        push_exp(32'hFF); chk("pre_rst_select", 32'(sel1));
        #2 rst = 1'b1;
        #1;
        push_exp(32'h5A); chk("arst_select", 32'(sel1));
        push_exp(0);      chk("arst_out", 32'(out1));
        push_exp(0);      chk("arst_loaded", 32'(ld1));
        push_exp(0);      chk("arst_count", 32'(d1.u_counter.count));
        tick();
        rst = 1'b0;

        // Three-lane cell: pad bit at the top of shadow is dropped
        beat3(3'b101);
        beat3(3'b100);
        push_exp(0); chk("l3_loaded_at2", 32'(ld3));
        beat3(3'b010);
        push_exp(1); chk("l3_loaded_at3", 32'(ld3));
        cm3 = 1'b1; tick(); cm3 = 1'b0;
        push_exp(32'hA5); chk("l3_select", 32'(sel3));
        push_exp(0);      chk("l3_err", 32'(er3));

        // Two-cell chain with the first cell bypassed
        do_reset();
        bya = 1'b1;
        pat = 8'($urandom());
        for (int i = 0; i < 9; i++) begin
            b = (i < 8) ? pat[i] : 1'b1;
            cb_bits.push_back(b);
            push_exp(32'(b));
            beatc(b);
            chk("byp_out", 32'(outa));
        end
        push_exp(1); chk("chain_b_loaded", 32'(ldb));
        push_exp(0); chk("chain_a_count", 32'(ca.u_counter.count));
        push_exp(0); chk("chain_a_shadow", 32'(ca.shadow));
        cmb = 1'b1; tick(); cmb = 1'b0;
        for (int i = 0; i < 8; i++) exp_sel[i] = cb_bits[i];
        push_exp(32'(exp_sel)); chk("chain_b_select", 32'(selb));
        push_exp(32'h5A);       chk("chain_a_select", 32'(sela));
        cma = 1'b1; tick(); cma = 1'b0;
        push_exp(1);      chk("chain_a_err", 32'(era));
        push_exp(32'h5A); chk("chain_a_select2", 32'(sela));
        bya = 1'b0;

`ifdef CONFIG_READBACK_EN
        // Readback: captured select shifts out LSB first
        do_reset();
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) beat1(pat[i], 1'b0);
        commit1();
        cap1 = 1'b1; tick(); cap1 = 1'b0;
        push_exp(1); chk("rb_loaded", 32'(ld1));
        for (int i = 0; i < 8; i++) begin
            push_exp(32'(pat[i]));
            chk("rb_out", 32'(out1));
            beat1(1'b0, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
